// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
//   DefDataW / DefAddrW : default register width and select width
//   clr_state_e         : bulk-clear sequencer states
// Optional build macro used by regfile_param: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 3;

  typedef enum logic {
    StIdle,
    StClear
  } clr_state_e;

endpackage

// File: rtl/regfile_if.sv
// Bus between control unit / ALU (master) and the register file (slave).
//   cload, csel, cin : write request, address, data
//   asel, bsel       : read addresses
//   aout, bout       : read data
//   clr_req          : bulk clear request
//   busy, clr_done   : clear sequencer status
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) ();

  logic              cload;
  logic [ADDR_W-1:0] csel;
  logic [DATA_W-1:0] cin;
  logic [ADDR_W-1:0] asel;
  logic [ADDR_W-1:0] bsel;
  logic [DATA_W-1:0] aout;
  logic [DATA_W-1:0] bout;
  logic              clr_req;
  logic              busy;
  logic              clr_done;

  modport master (
    output cload, csel, cin, asel, bsel, clr_req,
    input  aout, bout, busy, clr_done
  );

  modport slave (
    input  cload, csel, cin, asel, bsel, clr_req,
    output aout, bout, busy, clr_done
  );

endinterface

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: sweeps every register to zero, one per cycle.
//   clk, rst  : clock, async active-high reset
//   clr_req   : start a sweep (sampled only in idle)
//   busy      : high for the DEPTH sweep cycles
//   clr_done  : one-cycle pulse after the last register is cleared
//   clr_we    : zero-write enable to the array
//   clr_addr  : register being cleared this cycle
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        // clr_req is ignored here; a held request restarts from idle next edge
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q == StClear);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;
  assign clr_done = done_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: DATA_W x 2**ADDR_W, two combinational read
// ports, one write port committed through a one-stage pending register, and
// a hardware bulk-clear sweep.
//   clk, rst : clock, async active-high reset
//   bus      : regfile_if.slave (write, read, clear request/status)
// Build option: define REGFILE_BYPASS_EN to forward the pending write to the
// read ports, hiding the one-cycle commit latency.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              pend_v_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_take;
  logic              commit;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .busy     (busy),
    .clr_done (bus.clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.busy = busy;

  // A clear request in idle wins: the new write is dropped and the pending
  // one is discarded rather than committed.
  assign wr_take = bus.cload & ~busy & ~bus.clr_req;
  assign commit  = pend_v_q & ~busy & ~bus.clr_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      pend_v_q <= wr_take;
      if (wr_take) begin
        pend_addr_q <= bus.csel;
        pend_data_q <= bus.cin;
      end
    end
  end

  // pend_v is never set while busy, so the two write sources are exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (commit) begin
      mem_q[pend_addr_q] <= pend_data_q;
    end
  end

  logic [DATA_W-1:0] rd_a, rd_b;

  always_comb begin
    rd_a = mem_q[bus.asel];
    rd_b = mem_q[bus.bsel];
`ifdef REGFILE_BYPASS_EN
    if (pend_v_q && (bus.asel == pend_addr_q)) rd_a = pend_data_q;
    if (pend_v_q && (bus.bsel == pend_addr_q)) rd_b = pend_data_q;
`endif
  end

  assign bus.aout = rd_a;
  assign bus.bout = rd_b;

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised multi-port register file: two combinational read ports, one write port with a one-stage write pipeline, and a hardware bulk-clear sequencer. Generalises the fixed 8x8 register bank to DATA_W x 2**ADDR_W. Sits between the control unit, which drives the selects and load, and the ALU, which consumes aout/bout and produces cin.

Parameters:
DATA_W, 8, width of each register and of cin/aout/bout
ADDR_W, 3, select width; DEPTH = 2**ADDR_W registers

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high; clears all state immediately
cload  in  1  write request, sampled at posedge clk
csel  in  ADDR_W  write address
cin  in  DATA_W  write data
asel  in  ADDR_W  read address, port A
bsel  in  ADDR_W  read address, port B
aout  out  DATA_W  read data A, combinational from asel
bout  out  DATA_W  read data B, combinational from bsel
clr_req  in  1  request bulk clear of all registers, sampled at posedge
busy  out  1  high while the clear sequencer is active
clr_done  out  1  one-cycle pulse on the cycle after the last register is cleared

Behaviour:
- Reset (async, rst=1): array all zero; pending-write valid=0; FSM=IDLE; sweep counter=0; busy=0; clr_done=0; aout=bout=0.
- Write pipeline: at edge N, if IDLE and cload=1 and clr_req=0, capture {csel,cin} into pending register, pend_v=1. At edge N+1, pending data is committed to array[pend_addr]. A new write may be captured at the same edge, giving back-to-back throughput of 1 write/cycle.
- Commit latency: data written at edge N is visible in the array after edge N+1.
- Reads: aout=array[asel], bout=array[bsel], purely combinational; the same address on both ports is legal.
- FSM states: IDLE, CLEAR.
- IDLE -> CLEAR when clr_req=1 at an edge. At that same edge: pend_v cleared without commit (the pending write is discarded), cload ignored, counter=0, busy=1.
- CLEAR: each edge writes array[counter]=0 and increments counter. When counter==DEPTH-1 is written: -> IDLE, busy=0, clr_done=1 for exactly one cycle. Total duration is DEPTH cycles with busy=1.
- During CLEAR, cload and clr_req are ignored. Writes are dropped, not queued.
- clr_req held high at clear completion starts a new clear on the next edge, since the IDLE check comes first.
- Reads during CLEAR return the current array contents, with already-swept entries reading 0.
- Reset asserted mid-clear or mid-write aborts immediately to the reset state.
- Counter width is ADDR_W; there is no wrap past DEPTH-1.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: when pend_v=1 and asel==pend_addr, aout=pend_data; the same rule applies to bsel/bout. Written data is therefore readable in the cycle right after edge N (zero visible latency).
- Undefined: no forwarding; reads return the old array value until after edge N+1.
- Either way: pend_v=0 during CLEAR, so there is no forwarding while busy.

Decomposition:
- Package regfile_pkg holds:
  - the state typedef (IDLE, CLEAR)
  - default constants for DATA_W and ADDR_W
- Sub-module regfile_clear_seq holds:
  - the FSM, sweep counter, busy and clr_done
  - outputs clr_we and clr_addr to the array write mux
- The array, pending register and read/bypass muxing stay in regfile_param.

Test Plan:
- Reset, then read all addresses -> aout=bout=0 for addr 0..7; busy=0, clr_done=0.
- cload=1, csel=3, cin=8'hA5 at edge N; asel=3 -> without bypass: old value 0 after N, 8'hA5 after N+1. With REGFILE_BYPASS_EN: 8'hA5 right after N.
- Back-to-back writes addr1=8'h11, addr2=8'h22, addr1=8'h33 on consecutive edges -> after settling, addr1=8'h33 and addr2=8'h22. With asel=bsel=1, both ports read 8'h33.
- Fill all 8 registers with 8'hFF, pulse clr_req -> busy=1 for 8 cycles; entries read 0 progressively in order 0..7; single clr_done pulse; busy=0 afterwards. A cload to addr5=8'h55 during CLEAR leaves addr5=0.
- Same-edge cload (addr2=8'h77) and clr_req -> write dropped, clear runs, addr2=0. Write captured one edge before clr_req -> discarded, addr reads 0.
- Assert rst mid-clear (counter=4) with addrs 5..7 still 8'hFF -> immediately busy=0, all reads 0, FSM in IDLE.
